// File: rtl/cfg_delay_line_pkg.sv
// Shared constants and helpers for the configurable delay line.
// Provides the depth ceiling and width/clamp helper functions.
package cfg_delay_line_pkg;

  localparam int DL_MAX_SUPPORTED = 16;

  function automatic int dl_clog2(
    input int v
  );
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int dl_clamp(
    input int req,
    input int lim
  );
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/cfg_delay_line_stage.sv
// One delay stage: data plus valid tag register.
// Ports: clk, rst (async), clr (sync), ce, d/d_vld in, q/q_vld out.
module dl_stage #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else if (clr) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else if (ce) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/cfg_delay_line.sv
// Run-time configurable delay line with valid tags, flush, busy.
// Ports: clk, rst, ce, flush, cfg_we, cfg_depth, din, din_vld,
//        dout, dout_vld, depth, busy.
module cfg_delay_line
  import cfg_delay_line_pkg::*;
#(
  parameter int WIDTH         = 18,
  parameter int MAX_DEPTH     = 4,
  parameter int DEFAULT_DEPTH = 1,
  parameter int DW            = dl_clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic [DW-1:0]    cfg_depth,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [DW-1:0]    depth,
  output logic             busy
);

  localparam logic [DW-1:0] MAX_D =
    DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DEF_D =
    DW'(dl_clamp(DEFAULT_DEPTH, MAX_DEPTH));

  generate
    if (MAX_DEPTH > DL_MAX_SUPPORTED) begin : g_chk_max
      $error("cfg_delay_line: MAX_DEPTH exceeds 16");
    end
    if (MAX_DEPTH < 1) begin : g_chk_min
      $error("cfg_delay_line: MAX_DEPTH must be >= 1");
    end
    if (DEFAULT_DEPTH < 0 ||
        DEFAULT_DEPTH > MAX_DEPTH) begin : g_chk_def
      $error("cfg_delay_line: DEFAULT_DEPTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] sd [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] sv;
  logic [DW-1:0] cfg_clamped;
  logic clr;

  // A depth change also empties the line so no
  // stale sample shows up at the new tap.
  assign clr = cfg_we | flush;

  always_comb begin
    cfg_clamped = cfg_depth;
    if (cfg_depth > MAX_D) begin
      cfg_clamped = MAX_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= DEF_D;
    end else if (cfg_we) begin
      depth <= cfg_clamped;
    end
  end

  genvar k;
  generate
    for (k = 0; k < MAX_DEPTH; k++) begin : g_stg
      if (k == 0) begin : g_head
        dl_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk   (clk),
          .rst   (rst),
          .clr   (clr),
          .ce    (ce),
          .d     (din),
          .d_vld (din_vld),
          .q     (sd[k]),
          .q_vld (sv[k])
        );
      end else begin : g_body
        dl_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk   (clk),
          .rst   (rst),
          .clr   (clr),
          .ce    (ce),
          .d     (sd[k-1]),
          .d_vld (sv[k-1]),
          .q     (sd[k]),
          .q_vld (sv[k])
        );
      end
    end
  endgenerate

  // Depth 0 is a pure combinational bypass.
  always_comb begin
    dout     = din;
    dout_vld = din_vld;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (depth == DW'(i + 1)) begin
        dout     = sd[i];
        dout_vld = sv[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DW'(i) < depth) begin
        busy = busy | sv[i];
      end
    end
  end

endmodule

// File: tb/tb_cfg_delay_line.sv
// Scoreboard bench for cfg_delay_line against a history model.
// Driver pushes expectations; negedge monitor pops and compares.
module tb_cfg_delay_line;

  localparam int WIDTH = 18;
  localparam int MAXD  = 4;
  localparam int DW    = 3;

  logic             clk;
  logic             rst;
  logic             ce;
  logic             flush;
  logic             cfg_we;
  logic [DW-1:0]    cfg_depth;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [DW-1:0]    depth;
  logic             busy;

  cfg_delay_line #(
    .WIDTH         (WIDTH),
    .MAX_DEPTH     (MAXD),
    .DEFAULT_DEPTH (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .flush     (flush),
    .cfg_we    (cfg_we),
    .cfg_depth (cfg_depth),
    .din       (din),
    .din_vld   (din_vld),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .depth     (depth),
    .busy      (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             v;
  } smp_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             v;
    logic             b;
    logic [DW-1:0]    dep;
  } exp_t;

  smp_t hist[$];
  exp_t exp_q[$];
  int   mdepth;
  int   n_chk;
  int   n_pass;
  bit   done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string name,
    input int    act,
    input int    req
  );
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, req);
  endtask

  // Model: output is the sample that entered exactly
  // N enabled edges ago since the last clear.
  task automatic step(
    input logic             r,
    input logic             c,
    input logic             f,
    input logic             w,
    input logic [DW-1:0]    cd,
    input logic [WIDTH-1:0] d,
    input logic             v
  );
    exp_t e;
    smp_t s;
    int   sz;
    @(posedge clk);
    #1;
    rst = r; ce = c; flush = f;
    cfg_we = w; cfg_depth = cd;
    din = d; din_vld = v;
    if (r) begin
      hist.delete();
      mdepth = 1;
    end
    sz = hist.size();
    e.dep = DW'(mdepth);
    e.b = 1'b0;
    if (mdepth == 0) begin
      e.d = d;
      e.v = v;
    end else begin
      e.d = '0;
      e.v = 1'b0;
      if (sz >= mdepth) begin
        e.d = hist[sz - mdepth].d;
        e.v = hist[sz - mdepth].v;
      end
      for (int j = 1; j <= mdepth; j++) begin
        if (j <= sz) e.b = e.b | hist[sz - j].v;
      end
    end
    exp_q.push_back(e);
    if (!r) begin
      if (w) begin
        hist.delete();
        mdepth = (int'(cd) > MAXD) ? MAXD : int'(cd);
      end else if (f) begin
        hist.delete();
      end else if (c) begin
        s.d = d;
        s.v = v;
        hist.push_back(s);
        if (hist.size() > MAXD) void'(hist.pop_front());
      end
    end
  endtask

  task automatic run(
    input logic [WIDTH-1:0] d,
    input logic             v
  );
    step(0, 1, 0, 0, 0, d, v);
  endtask

  task automatic cfg(input logic [DW-1:0] cd);
    step(0, 1, 0, 1, cd, 18'h3FFFF, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dout_vld", int'(dout_vld), int'(e.v));
        check("dout", int'(dout), int'(e.d));
        check("busy", int'(busy), int'(e.b));
        check("depth", int'(depth), int'(e.dep));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit hit, done=%0d need 1",
             done);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [DW-1:0]    rcd;
    logic [WIDTH-1:0] rd;
    n_chk = 0; n_pass = 0; done = 0;
    mdepth = 1;
    rst = 1; ce = 0; flush = 0; cfg_we = 0;
    cfg_depth = 0; din = 0; din_vld = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 18'h00AB, 1);
    run(18'h00AB, 1);
    run(18'h0, 0);
    run(18'h0, 0);
    cfg(3);
    run(18'h1, 1);
    run(18'h2, 1);
    run(18'h3, 1);
    for (int i = 0; i < 4; i++) run(18'h0, 0);
    cfg(2);
    run(18'h5, 1);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 18'h11, 1);
    for (int i = 0; i < 3; i++) run(18'h0, 0);
    cfg(4);
    run(18'hA, 1);
    run(18'hB, 1);
    run(18'hC, 1);
    step(0, 1, 1, 0, 0, 18'h7, 1);
    for (int i = 0; i < 6; i++) run(18'h0, 0);
    cfg(0);
    for (int i = 0; i < 4; i++)
      run(WIDTH'($urandom), 1'($urandom));
    cfg(7);
    run(18'h2A, 1);
    for (int i = 0; i < 5; i++) run(18'h0, 0);
    cfg(3);
    run(18'h31, 1);
    run(18'h32, 1);
    step(1, 1, 0, 0, 0, 18'h33, 1);
    for (int i = 0; i < 5; i++) run(18'h0, 0);
    for (int i = 0; i < 3000; i++) begin
      rcd = DW'($urandom_range(0, 7));
      rd  = WIDTH'($urandom);
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 5),
           rcd, rd, 1'($urandom));
    end
    run(18'h0, 0);
    @(posedge clk);
    @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cfg_delay_line.md
Name: cfg_delay_line

Overview:
- Parametrised successor to the fixed-depth pipeline register used on the DSP48A1 operand and result paths.
- Adds a per-sample valid tag, a run-time depth register (0..MAX_DEPTH), a flush input and occupancy status.
- Lets one instance re-time A/B/C/D/M/P paths to match the chosen DSP latency without re-synthesis.
- Sits between operand sources and the DSP core, one instance per operand.

Parameters:
- WIDTH, 18, data bit width (>=1).
- MAX_DEPTH, 4, number of physical stages (>=1).
- DEFAULT_DEPTH, 1, active depth after reset (0..MAX_DEPTH).
- DW, $clog2(MAX_DEPTH+1), width of depth fields (derived, do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  async, active-high reset.
- ce  in  1  clock enable for the shift.
- flush  in  1  sync clear of all valid tags and data.
- cfg_we  in  1  load cfg_depth into the depth register.
- cfg_depth  in  DW  requested depth.
- din  in  WIDTH  sample in.
- din_vld  in  1  sample valid.
- dout  out  WIDTH  delayed sample.
- dout_vld  out  1  delayed valid.
- depth  out  DW  current active depth (registered).
- busy  out  1  any valid tag in stages 0..depth-1.

Behaviour:
- Reset: rst asserted asynchronously clears all stage data and valid tags to 0, and sets depth=DEFAULT_DEPTH. dout_vld=0 and busy=0 during and after reset. dout=0 if DEFAULT_DEPTH>0, otherwise dout=din.
- Storage: stage[0..MAX_DEPTH-1], each with data and a valid tag.
- Shift (ce=1): on the clock edge, stage[0]<=din/din_vld and stage[k]<=stage[k-1]. All MAX_DEPTH stages always shift, regardless of depth.
- Hold (ce=0): all stages hold.
- Output tap, depth=N>0: dout/dout_vld = stage[N-1]. Latency is exactly N ce-qualified edges.
- Output tap, depth=0: combinational bypass, dout=din and dout_vld=din_vld. busy=0.
- Flush (flush=1): at the edge, all data and valid tags are cleared to 0, independent of ce. din is not captured that cycle.
- Config (cfg_we=1): at the edge, depth <= min(cfg_depth, MAX_DEPTH). An implicit flush happens at the same edge, so stale samples never appear at the new tap. din is not captured that cycle. The new depth applies from the next cycle.
- Priority: rst > cfg_we > flush > ce.
- Clamping: cfg_depth > MAX_DEPTH loads MAX_DEPTH. No error flag.
- busy: OR of the valid tags of stage[0..depth-1], computed combinationally from registered state.
- Reset mid-stream: all in-flight samples are lost. No partial output.
- dout is a don't-care when dout_vld=0, except after reset or flush, where it must read 0.

Decomposition:
- Shared include/package holds the clog2 helper and a constant for maximum supported depth (16). cfg_delay_line asserts MAX_DEPTH <= 16 at elaboration.
- Sub-module dl_stage holds one data+valid register with async rst, sync clr and ce. It is instantiated MAX_DEPTH times in a generate loop.
- The tap mux and busy reduction stay in the top module.

Test Plan:
- Reset/default: WIDTH=18, MAX_DEPTH=4, DEFAULT_DEPTH=1. Release rst, hold ce=1, din=0x00AB, vld=1 → dout=0x00AB, dout_vld=1 one edge later. depth=1. Before the first edge: dout=0, dout_vld=0.
- Depth 3 latency: cfg_we with cfg_depth=3, then stream 0x1,0x2,0x3 with vld=1 → dout_vld rises on the 3rd edge after 0x1 with dout=0x1. The next two edges give 0x2, 0x3. busy=1 while any is in flight.
- ce gating: depth=2, send 0x5, deassert ce for 4 cycles → dout/dout_vld frozen. Reassert ce → 0x5 emerges after exactly 2 enabled edges total.
- Flush and priority: depth=4 with 3 samples in flight; assert flush and ce together with din=0x7, vld=1 → next cycle busy=0, dout_vld=0, dout=0. 0x7 is never output.
- Bypass and clamp: cfg_depth=0 → dout follows din in the same cycle, busy=0. Then cfg_depth=7 → depth reads 4 and latency is 4.
- Async reset mid-stream: depth=3 with samples in flight; pulse rst between edges → dout_vld and busy drop immediately. depth returns to 1 and no stale sample appears afterward.
